// File: rtl/sar_search.sv
// sar_search: successive-approximation controller for a magnitude comparator.
// Drives a trial value onto the comparator's b input. It reads the one-hot
// eq/gt/lt result and resolves the unknown a operand MSB first. The search
// ends early when the comparator reports equality.
module sar_search #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       cmp_y,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_TEST = 1'b1;

  localparam logic [2:0] Y_EQ = 3'b001;
  localparam logic [2:0] Y_GT = 3'b010;
  localparam logic [2:0] Y_LT = 3'b100;

  logic [0:0]       state_reg,   state_next;
  logic [WIDTH-1:0] acc_reg,     acc_next;
  logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
  logic [WIDTH-1:0] trial_reg,   trial_next;
  logic [WIDTH-1:0] result_reg,  result_next;
  logic             done_reg,    done_next;
  logic             error_reg,   error_next;

  // Position of the next bit to try, and its single-bit mask.
  logic [IDX_W-1:0] idx_dec;
  logic [WIDTH-1:0] step_mask;
  logic [WIDTH-1:0] msb_mask;

  assign idx_dec   = bit_idx_reg - IDX_W'(1);
  assign step_mask = WIDTH'(1) << idx_dec;
  assign msb_mask  = WIDTH'(1) << (WIDTH - 1);

  // Next-state logic: accept start in IDLE, then narrow the trial in TEST.
  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    bit_idx_next = bit_idx_reg;
    trial_next   = trial_reg;
    result_next  = result_reg;
    error_next   = error_reg;
    done_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        trial_next = '0;
        if (start) begin
          state_next   = ST_TEST;
          acc_next     = '0;
          bit_idx_next = IDX_W'(WIDTH - 1);
          trial_next   = msb_mask;
          result_next  = '0;
          error_next   = 1'b0;
        end
      end

      ST_TEST: begin
        case (cmp_y)
          Y_EQ: begin
            // Exact hit: stop early; the trial itself is the answer.
            result_next = trial_reg;
            done_next   = 1'b1;
            trial_next  = '0;
            state_next  = ST_IDLE;
          end
          Y_GT: begin
            // Target is above the trial, so the tested bit stays set.
            if (bit_idx_reg != '0) begin
              acc_next     = trial_reg;
              bit_idx_next = idx_dec;
              trial_next   = trial_reg | step_mask;
            end else begin
              result_next = trial_reg;
              done_next   = 1'b1;
              trial_next  = '0;
              state_next  = ST_IDLE;
            end
          end
          Y_LT: begin
            // Target is below the trial, so the tested bit is dropped.
            if (bit_idx_reg != '0) begin
              bit_idx_next = idx_dec;
              trial_next   = acc_reg | step_mask;
            end else begin
              result_next = acc_reg;
              done_next   = 1'b1;
              trial_next  = '0;
              state_next  = ST_IDLE;
            end
          end
          default: begin
            // Result not one-hot: the comparator cannot be trusted, so abort.
            error_next  = 1'b1;
            result_next = '0;
            done_next   = 1'b1;
            trial_next  = '0;
            state_next  = ST_IDLE;
          end
        endcase
      end

      default: begin
        state_next = ST_IDLE;
        trial_next = '0;
      end
    endcase
  end

  // State registers; reset aborts any search without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      acc_reg     <= '0;
      bit_idx_reg <= '0;
      trial_reg   <= '0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      bit_idx_reg <= bit_idx_next;
      trial_reg   <= trial_next;
      result_reg  <= result_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
    end
  end

  assign trial  = trial_reg;
  assign busy   = (state_reg == ST_TEST);
  assign done   = done_reg;
  assign result = result_reg;
  assign error  = error_reg;

endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed, table-driven bench for sar_search with a
// behavioural 3-bit magnitude comparator closing the loop.
module tb_sar_search;

  localparam int WIDTH = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [2:0]       cmp_y;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             error;

  logic [WIDTH-1:0] target;
  logic             force_en;
  logic [2:0]       force_val;
  logic [2:0]       cmp_model;

  int n_vec;
  int n_bad;

  // Comparator: a = target, b = trial; y = {lt, gt, eq}
  assign cmp_model = {(target < trial), (target > trial), (target == trial)};
  assign cmp_y     = force_en ? force_val : cmp_model;

  sar_search #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_y  (cmp_y),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .error  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]            tgt;
    logic [WIDTH-1:0]            res;
    int                          n;
    logic [2:0][WIDTH-1:0]       trials;  // trials[0] is the first trial
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One complete search with cycle-by-cycle trial checking.
  task automatic run_search(input vec_t v, input bit pulse_mid);
    target = v.tgt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      chk("busy_in_test", int'(busy), 1);
      chk("trial_step", int'(trial), int'(v.trials[k]));
      chk("done_early", int'(done), 0);
      if (k == 0) chk("error_cleared", int'(error), 0);
      if (pulse_mid && k == 0) start = 1'b1;
      if (pulse_mid && k == 1) start = 1'b0;
      @(negedge clk);
    end
    chk("done_pulse", int'(done), 1);
    chk("busy_at_done", int'(busy), 0);
    chk("trial_at_done", int'(trial), 0);
    chk("result", int'(result), int'(v.res));
    chk("error_at_done", int'(error), 0);
    @(negedge clk);
    chk("done_single", int'(done), 0);
    chk("result_held", int'(result), int'(v.res));
    chk("idle_after", int'(busy), 0);
    $display("search target=%0d result=%0d tests=%0d", v.tgt, result, v.n);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    vecs[0] = '{tgt: 3'd0, res: 3'd0, n: 3, trials: {3'd1, 3'd2, 3'd4}};
    vecs[1] = '{tgt: 3'd1, res: 3'd1, n: 3, trials: {3'd1, 3'd2, 3'd4}};
    vecs[2] = '{tgt: 3'd2, res: 3'd2, n: 2, trials: {3'd0, 3'd2, 3'd4}};
    vecs[3] = '{tgt: 3'd3, res: 3'd3, n: 3, trials: {3'd3, 3'd2, 3'd4}};
    vecs[4] = '{tgt: 3'd4, res: 3'd4, n: 1, trials: {3'd0, 3'd0, 3'd4}};
    vecs[5] = '{tgt: 3'd5, res: 3'd5, n: 3, trials: {3'd5, 3'd6, 3'd4}};
    vecs[6] = '{tgt: 3'd6, res: 3'd6, n: 2, trials: {3'd0, 3'd6, 3'd4}};
    vecs[7] = '{tgt: 3'd7, res: 3'd7, n: 3, trials: {3'd7, 3'd6, 3'd4}};

    rst       = 1'b1;
    start     = 1'b0;
    target    = '0;
    force_en  = 1'b0;
    force_val = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_trial", int'(trial), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_error", int'(error), 0);
    $display("reset released");

    // Sweep every target value
    for (int i = 0; i < 8; i++) run_search(vecs[i], 1'b0);

    // Non-one-hot comparator result in the first TEST cycle
    force_en  = 1'b1;
    force_val = 3'b011;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_busy", int'(busy), 1);
    chk("err_trial", int'(trial), 4);
    @(negedge clk);
    chk("err_done", int'(done), 1);
    chk("err_flag", int'(error), 1);
    chk("err_result", int'(result), 0);
    chk("err_trial_idle", int'(trial), 0);
    force_en = 1'b0;
    @(negedge clk);
    chk("err_done_single", int'(done), 0);
    chk("err_held", int'(error), 1);
    $display("error search result=%0d error=%0d", result, error);
    run_search(vecs[6], 1'b0);

    // Back-to-back: start held in the done cycle is accepted
    target = 3'd2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_trial0", int'(trial), 4);
    @(negedge clk);
    chk("b2b_trial1", int'(trial), 2);
    @(negedge clk);
    chk("b2b_done1", int'(done), 1);
    chk("b2b_result1", int'(result), 2);
    start  = 1'b1;
    target = 3'd6;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy2", int'(busy), 1);
    chk("b2b_trial2", int'(trial), 4);
    chk("b2b_result_clr", int'(result), 0);
    @(negedge clk);
    chk("b2b_trial3", int'(trial), 6);
    @(negedge clk);
    chk("b2b_done2", int'(done), 1);
    chk("b2b_result2", int'(result), 6);
    $display("back-to-back searches result=%0d", result);

    // Reset during the second TEST cycle
    target = 3'd5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_trial0", int'(trial), 4);
    @(negedge clk);
    chk("mid_trial1", int'(trial), 6);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_trial", int'(trial), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_error", int'(error), 0);
    @(negedge clk);
    chk("mid_no_done", int'(done), 0);
    chk("mid_still_idle", int'(busy), 0);
    $display("reset mid-search busy=%0d done=%0d", busy, done);

    // Start pulsed while busy is ignored
    run_search(vecs[3], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
